div_iter: RTL and testbench

Iterative radix-2 restoring divider for the five-stage pipeline's EX stage, implementing MIPS DIV and DIVU. It produces the quotient and remainder of a 32-bit dividend and divisor, one quotient bit per cycle, using a 33-bit trial subtraction. The pipeline stalls EX while the divider is busy and writes HI/LO on `div_done`. It is the subtractive counterpart of the existing carry-lookahead adder datapath.

---
 rtl/div_iter.sv | 82 ++++++++
 tb/tb_div_iter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for MIPS DIV/DIVU, one quotient bit per cycle.
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             div_start,
   input  logic             div_signed,
   input  logic             div_cancel,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             div_ready,
   output logic             div_busy,
   output logic             div_done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] rem, quo, dvs, a_abs, b_abs;
   logic [WIDTH:0] trial;
   logic neg_q, neg_r, start_ok, fix_ok;
   always_comb begin
      start_ok = state == IDLE && div_start && !div_cancel;
      fix_ok   = state == FIX && !div_cancel;
      a_abs    = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
      b_abs    = (div_signed && divisor[WIDTH-1]) ? -divisor : divisor;
      // trial uses the full shifted remainder so a set rem msb is never lost
      trial    = {rem, quo[WIDTH-1]} - {1'b0, dvs};
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start_ok ? CALC : IDLE;
         CALC:    state_nx = div_cancel ? IDLE : (cnt == CW'(WIDTH - 1)) ? FIX : CALC;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      div_ready = state == IDLE;
      div_busy  = state == CALC || state == FIX;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt         <= '0;
         rem         <= '0;
         quo         <= '0;
         dvs         <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         div_done    <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         if (start_ok) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= a_abs;
            dvs   <= b_abs;
            neg_q <= div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= div_signed & dividend[WIDTH-1];
         end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
         end
         div_done <= fix_ok;
         if (fix_ok) begin
            quotient    <= neg_q ? -quo : quo;
            remainder   <= neg_r ? -rem : rem;
            div_by_zero <= dvs == '0;
         end
      end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: scenario tasks plus randomized regression against an arithmetic reference model.
module tb_div_iter;
   logic clk = 1'b0, reset = 1'b1, div_start = 1'b0, div_signed = 1'b0, div_cancel = 1'b0;
   logic [31:0] dividend = '0, divisor = '0;
   logic div_ready, div_busy, div_done, div_by_zero;
   logic [31:0] quotient, remainder;
   int checks = 0, fails = 0;

   div_iter #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .div_start(div_start), .div_signed(div_signed),
      .div_cancel(div_cancel), .dividend(dividend), .divisor(divisor),
      .div_ready(div_ready), .div_busy(div_busy), .div_done(div_done),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic void model(input logic [31:0] a, b, input logic s, output logic [31:0] q, r);
      longint sa, sb;
      if (b == 0) begin
         q = (s && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
         r = a;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = 32'(sa / sb);
         r = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic run_op(input logic [31:0] a, b, input logic s,
                         output logic [31:0] q, r, output logic dz, output int lat, output int bcnt);
      @(negedge clk);
      dividend = a; divisor = b; div_signed = s; div_start = 1'b1;
      @(posedge clk); #1;
      div_start = 1'b0; dividend = $urandom; divisor = $urandom; div_signed = $urandom_range(0, 1);
      lat = 0;
      bcnt = int'(div_busy);
      while (!div_done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (div_busy) bcnt++;
      end
      q = quotient; r = remainder; dz = div_by_zero;
   endtask

   task automatic test_reset();
      #1;
      checks++; if ({div_ready, div_busy, div_done} !== 3'b100) begin fails++; $display("FAIL reset_flags got %b want 100", {div_ready, div_busy, div_done}); end
      checks++; if ({quotient, remainder, div_by_zero} !== 65'h0) begin fails++; $display("FAIL reset_outputs got q=%h r=%h dz=%b want 0", quotient, remainder, div_by_zero); end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_basic();
      logic [31:0] q, r; logic dz; int lat, bcnt;
      run_op(100, 7, 1'b0, q, r, dz, lat, bcnt);
      checks++; if (lat !== 33) begin fails++; $display("FAIL basic_latency got %0d want 33", lat); end
      checks++; if (bcnt !== 33) begin fails++; $display("FAIL basic_busy_cycles got %0d want 33", bcnt); end
      checks++; if (q !== 32'd14 || r !== 32'd2 || dz !== 1'b0) begin fails++; $display("FAIL basic_result got q=%0d r=%0d dz=%b want 14 2 0", q, r, dz); end
      checks++; if (div_ready !== 1'b1 || div_busy !== 1'b0) begin fails++; $display("FAIL basic_ready_in_done got rdy=%b busy=%b want 1 0", div_ready, div_busy); end
      @(posedge clk); #1;
      checks++; if (div_done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b want 0", div_done); end
   endtask

   task automatic test_fixed();
      logic [31:0] av[7] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h8000_0000, 32'd5, 32'hFFFF_FFF9};
      logic [31:0] bv[7] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0};
      logic sv[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] qv[7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1};
      logic [31:0] rv[7] = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'd5, 32'hFFFF_FFF9};
      logic [31:0] q, r; logic dz; int lat, bcnt;
      for (int i = 0; i < 7; i++) begin
         run_op(av[i], bv[i], sv[i], q, r, dz, lat, bcnt);
         checks++; if (q !== qv[i] || r !== rv[i]) begin fails++; $display("FAIL fixed_%0d got q=%h r=%h want q=%h r=%h", i, q, r, qv[i], rv[i]); end
         checks++; if (dz !== (bv[i] == 0)) begin fails++; $display("FAIL fixed_dz_%0d got %b want %b", i, dz, bv[i] == 0); end
      end
   endtask

   task automatic test_busy_start();
      int dones = 0, first = -1;
      logic [31:0] q = '0, r = '0;
      @(negedge clk);
      dividend = 1000; divisor = 10; div_signed = 1'b0; div_start = 1'b1;
      @(posedge clk); #1; div_start = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         if (c == 5) begin div_start = 1'b1; dividend = 77; divisor = 5; end
         if (c == 6) div_start = 1'b0;
         @(posedge clk); #1;
         if (div_done) begin dones++; if (first < 0) begin first = c; q = quotient; r = remainder; end end
      end
      checks++; if (dones !== 1) begin fails++; $display("FAIL busy_start_dones got %0d want 1", dones); end
      checks++; if (first !== 33) begin fails++; $display("FAIL busy_start_latency got %0d want 33", first); end
      checks++; if (q !== 32'd100 || r !== 32'd0) begin fails++; $display("FAIL busy_start_result got q=%0d r=%0d want 100 0", q, r); end
   endtask

   task automatic test_cancel();
      int dones = 0;
      logic [31:0] q, r; logic dz; int lat, bcnt;
      @(negedge clk);
      dividend = 50; divisor = 3; div_signed = 1'b0; div_start = 1'b1;
      @(posedge clk); #1; div_start = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      div_cancel = 1'b1;
      @(posedge clk); #1; div_cancel = 1'b0;
      checks++; if (div_ready !== 1'b1 || div_done !== 1'b0) begin fails++; $display("FAIL cancel_idle got rdy=%b done=%b want 1 0", div_ready, div_done); end
      checks++; if (quotient !== 32'd100 || remainder !== 32'd0) begin fails++; $display("FAIL cancel_hold got q=%0d r=%0d want 100 0", quotient, remainder); end
      repeat (40) begin @(posedge clk); #1; if (div_done) dones++; end
      checks++; if (dones !== 0) begin fails++; $display("FAIL cancel_no_done got %0d want 0", dones); end
      @(negedge clk); div_start = 1'b1; div_cancel = 1'b1;
      @(posedge clk); #1; div_start = 1'b0; div_cancel = 1'b0;
      checks++; if (div_busy !== 1'b0) begin fails++; $display("FAIL cancel_suppress_start got busy=%b want 0", div_busy); end
      run_op(9, 3, 1'b0, q, r, dz, lat, bcnt);
      checks++; if (q !== 32'd3 || r !== 32'd0 || lat !== 33) begin fails++; $display("FAIL cancel_restart got q=%0d r=%0d lat=%0d want 3 0 33", q, r, lat); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] q, r; logic dz; int lat, bcnt;
      run_op(1234, 10, 1'b0, q, r, dz, lat, bcnt);
      dividend = 32'hFFFF_FF9C; divisor = 32'd9; div_signed = 1'b1; div_start = 1'b1;
      @(posedge clk); #1; div_start = 1'b0;
      checks++; if (div_done !== 1'b0 || div_busy !== 1'b1) begin fails++; $display("FAIL b2b_accept got done=%b busy=%b want 0 1", div_done, div_busy); end
      lat = 0;
      while (!div_done && lat < 40) begin @(posedge clk); #1; lat++; end
      checks++; if (lat !== 33) begin fails++; $display("FAIL b2b_latency got %0d want 33", lat); end
      checks++; if (quotient !== 32'hFFFF_FFF5 || remainder !== 32'hFFFF_FFFF) begin fails++; $display("FAIL b2b_result got q=%h r=%h want fffffff5 ffffffff", quotient, remainder); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] q, r; logic dz; int lat, bcnt;
      @(negedge clk);
      dividend = 500; divisor = 0; div_signed = 1'b0; div_start = 1'b1;
      @(posedge clk); #1; div_start = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      reset = 1'b1; #1;
      checks++; if ({div_ready, div_busy, div_done} !== 3'b100) begin fails++; $display("FAIL mid_reset_flags got %b want 100", {div_ready, div_busy, div_done}); end
      checks++; if ({quotient, remainder, div_by_zero} !== 65'h0) begin fails++; $display("FAIL mid_reset_outputs got q=%h r=%h dz=%b want 0", quotient, remainder, div_by_zero); end
      #1; reset = 1'b0;
      run_op(100, 7, 1'b0, q, r, dz, lat, bcnt);
      checks++; if (q !== 32'd14 || r !== 32'd2 || lat !== 33) begin fails++; $display("FAIL mid_reset_rerun got q=%0d r=%0d lat=%0d want 14 2 33", q, r, lat); end
   endtask

   task automatic test_random();
      logic [31:0] sp[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd3};
      logic [31:0] a, b, q, r, eq, er; logic s, dz; int lat, bcnt;
      for (int n = 0; n < 1500; n++) begin
         a = ($urandom_range(0, 7) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 5) == 0) ? sp[$urandom_range(0, 5)] :
             ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
         s = $urandom_range(0, 1);
         model(a, b, s, eq, er);
         run_op(a, b, s, q, r, dz, lat, bcnt);
         checks++; if (q !== eq || r !== er || dz !== (b == 0) || lat !== 33) begin
            fails++; $display("FAIL rand_%0d a=%h b=%h s=%b got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=33", n, a, b, s, q, r, dz, lat, eq, er, b == 0);
         end
         if (b != 0) begin
            checks++; if (32'(q * b + r) !== a) begin fails++; $display("FAIL rand_identity_%0d got %h want %h", n, 32'(q * b + r), a); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fixed();
      test_busy_start();
      test_cancel();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
